tape_loader: RTL and testbench
==============================

Name: tape_loader

Overview:
- Host-side driver for the Turing-machine chip's button-style tape-entry interface (4-bit symbol, Next, Done).
- Buffers a tape of symbols written by an upstream source, then replays them as debounced-width Next pulses and a final Done pulse.
- Waits for the chip's compute-done flag, then captures the 11-bit display word for upstream.
- Sits between a host/test controller and the chip pins; it is the transmitter for the chip's tape receiver.

Parameters:
WIDTH, 4, symbol width in bits
DEPTH, 64, max symbols per tape (FIFO depth)
SETUP, 2, cycles data is held stable with strobe low, before and after each strobe (>=1)
PULSE, 2, cycles each Next/Done strobe is held high (>=1)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
wr_data  in  WIDTH  tape symbol from upstream
wr_last  in  1  marks final symbol of tape
wr_valid  in  1  upstream symbol valid
wr_ready  out  1  loader accepts symbol this cycle
input_data  out  WIDTH  symbol presented to chip
next  out  1  Next strobe to chip
done  out  1  Done strobe to chip
compute_done  in  1  chip finished flag (same clock domain)
display  in  11  chip display word
result  out  11  captured display word
result_valid  out  1  result holds a fresh capture
result_ack  in  1  upstream consumed result
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE, FIFO emptied, count=0; input_data=0, next=0, done=0, result=0, result_valid=0, busy=0; wr_ready=1 after release. Reset mid-stream aborts immediately; no partial strobe survives.
- wr_ready = (state==IDLE) && (count<DEPTH). Transfer occurs on wr_valid && wr_ready.
- States: IDLE, LEAD, STROBE, TRAIL, DLEAD, DSTROBE, WAIT, RESULT. One shared down-counter for phase timing.
- IDLE: accepts symbols. On transfer with wr_last=1, or on the transfer that makes count==DEPTH, go to LEAD next cycle. That transfer's symbol is included in the tape.
- LEAD: input_data=FIFO head, next=0 for SETUP cycles -> STROBE.
- STROBE: input_data=head, next=1 for PULSE cycles -> TRAIL.
- TRAIL: input_data=head, next=0 for SETUP cycles; on last TRAIL cycle pop head. If FIFO non-empty after pop -> LEAD, else -> DLEAD.
- Per symbol: exactly 2*SETUP+PULSE cycles; input_data never changes while next=1 or within SETUP cycles of it.
- DLEAD: input_data=0, done=0 for SETUP cycles -> DSTROBE.
- DSTROBE: done=1 for PULSE cycles -> WAIT.
- next and done are never high together. Outputs are registered (glitch-free).
- WAIT: when compute_done=1 is sampled, result<=display and result_valid<=1 in that edge -> RESULT. compute_done is ignored in all other states. No timeout.
- RESULT: result and result_valid held until result_ack=1 sampled; then result_valid<=0 -> IDLE. result itself keeps its value until the next capture.
- result_ack outside RESULT is ignored. wr_valid outside IDLE is not accepted (wr_ready=0).
- FIFO: circular, pointers wrap mod DEPTH, count 0..DEPTH. No pop when empty, no push when full.

Test Plan:
- Single symbol 0xA with wr_last, SETUP=2, PULSE=2 -> input_data=0xA; next high exactly cycles 3-4 after LEAD entry; done high exactly 2 cycles, 8 cycles after LEAD entry; busy=1 from LEAD.
- Tape 0x1,0x2,0x3 (last on 0x3), then compute_done=1 with display=0x5A5 -> three next pulses 6 cycles apart with matching input_data, one done pulse; result=0x5A5, result_valid=1 held until result_ack, then IDLE with wr_ready=1.
- 64 symbols 0x0..0xF repeating, none with wr_last -> wr_ready drops after the 64th transfer; streaming starts automatically; 64 next pulses in order, then done.
- compute_done=1 during STROBE -> no capture; later compute_done=1 in WAIT with display=0x123 -> result=0x123.
- Reset asserted mid-STROBE of symbol 2 -> next=0 and done=0 immediately; FIFO empty, state IDLE; a fresh 1-symbol tape then replays correctly.
- Second tape written after result_ack -> FIFO pointers wrapped correctly; symbols replay in write order.

Source files
------------

// File: rtl/tape_loader_if.sv
// Host-side channels of the tape loader: a symbol write stream in, and a
// captured display result out with an acknowledge.
interface tape_loader_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] wr_data;
  logic             wr_last;
  logic             wr_valid;
  logic             wr_ready;
  logic [10:0]      result;
  logic             result_valid;
  logic             result_ack;

  modport master (
    output wr_data, wr_last, wr_valid, result_ack,
    input  wr_ready, result, result_valid
  );

  modport slave (
    input  wr_data, wr_last, wr_valid, result_ack,
    output wr_ready, result, result_valid
  );
endinterface

// File: rtl/tape_loader.sv
// Buffers a tape of symbols, then replays them to the Turing-machine chip as
// Next strobes followed by a Done strobe, and captures the display word.
module tape_loader #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 64,
  parameter int SETUP = 2,
  parameter int PULSE = 2
) (
  input  logic             clock,
  input  logic             reset,
  tape_loader_if.slave     host,
  output logic [WIDTH-1:0] input_data,
  output logic             next,
  output logic             done,
  input  logic             compute_done,
  input  logic [10:0]      display,
  output logic             busy
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LEAD    = 3'd1;
  localparam logic [2:0] STROBE  = 3'd2;
  localparam logic [2:0] TRAIL   = 3'd3;
  localparam logic [2:0] DLEAD   = 3'd4;
  localparam logic [2:0] DSTROBE = 3'd5;
  localparam logic [2:0] WAIT    = 3'd6;
  localparam logic [2:0] RESULT  = 3'd7;

  localparam int MAXPH = (SETUP > PULSE) ? SETUP : PULSE;
  localparam int CW    = (MAXPH > 1) ? $clog2(MAXPH) : 1;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW    = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE - 1);
  localparam logic [NW-1:0] DEPTH_N  = NW'(DEPTH);
  localparam logic [NW-1:0] DEPTH_M1 = NW'(DEPTH - 1);
  localparam logic [NW-1:0] ONE_N    = NW'(1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [2:0]       state;
  logic [CW-1:0]    phase;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_next;
  logic [NW-1:0]    count;
  logic [10:0]      result_q;
  logic             result_valid_q;
  logic             push;
  logic             pop;
  logic             tape_end;

  assign host.wr_ready     = (state == IDLE) && (count < DEPTH_N);
  assign host.result       = result_q;
  assign host.result_valid = result_valid_q;
  assign busy              = (state != IDLE);

  assign push     = host.wr_valid && host.wr_ready;
  assign pop      = (state == TRAIL) && (phase == '0);
  assign tape_end = host.wr_last || (count == DEPTH_M1);
  assign rd_next  = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= host.wr_data;
    end
  end

  // Push only happens in IDLE and pop only in TRAIL, so they never coincide.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      count  <= count + 1'b1;
    end else if (pop) begin
      rd_ptr <= rd_next;
      count  <= count - 1'b1;
    end
  end

  // Strobes and symbol are loaded on the same edge as the state they belong to,
  // so the pins change only on clock edges and never mid-strobe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      phase          <= '0;
      input_data     <= '0;
      next           <= 1'b0;
      done           <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (push && tape_end) begin
            state      <= LEAD;
            phase      <= SETUP_LD;
            input_data <= (count == '0) ? host.wr_data : mem[rd_ptr];
          end
        end
        LEAD: begin
          if (phase == '0) begin
            state <= STROBE;
            phase <= PULSE_LD;
            next  <= 1'b1;
          end else begin
            phase <= phase - 1'b1;
          end
        end
        STROBE: begin
          if (phase == '0) begin
            state <= TRAIL;
            phase <= SETUP_LD;
            next  <= 1'b0;
          end else begin
            phase <= phase - 1'b1;
          end
        end
        TRAIL: begin
          if (phase == '0) begin
            phase <= SETUP_LD;
            if (count > ONE_N) begin
              state      <= LEAD;
              input_data <= mem[rd_next];
            end else begin
              state      <= DLEAD;
              input_data <= '0;
            end
          end else begin
            phase <= phase - 1'b1;
          end
        end
        DLEAD: begin
          if (phase == '0) begin
            state <= DSTROBE;
            phase <= PULSE_LD;
            done  <= 1'b1;
          end else begin
            phase <= phase - 1'b1;
          end
        end
        DSTROBE: begin
          if (phase == '0) begin
            state <= WAIT;
            done  <= 1'b0;
          end else begin
            phase <= phase - 1'b1;
          end
        end
        WAIT: begin
          if (compute_done) begin
            result_q       <= display;
            result_valid_q <= 1'b1;
            state          <= RESULT;
          end
        end
        RESULT: begin
          if (host.result_ack) begin
            result_valid_q <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tape_loader.sv
// Directed bench for tape_loader: replays tapes and compares the chip-side pins
// cycle by cycle against hand-derived strobe timing.
module tb_tape_loader;
  localparam int SETUP = 2;
  localparam int PULSE = 2;
  localparam int PER   = 2 * SETUP + PULSE;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  input_data;
  logic        next;
  logic        done;
  logic        compute_done = 1'b0;
  logic [10:0] display = '0;
  logic        busy;

  int checks = 0;
  int passes = 0;
  logic [3:0] tape [0:63];

  tape_loader_if #(.WIDTH(4)) hif ();

  tape_loader #(.WIDTH(4), .DEPTH(64), .SETUP(SETUP), .PULSE(PULSE)) dut (
    .clock        (clock),
    .reset        (reset),
    .host         (hif),
    .input_data   (input_data),
    .next         (next),
    .done         (done),
    .compute_done (compute_done),
    .display      (display),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic write_sym(input logic [3:0] sym, input logic last);
    hif.wr_data  = sym;
    hif.wr_last  = last;
    hif.wr_valid = 1'b1;
    step();
    hif.wr_valid = 1'b0;
    hif.wr_last  = 1'b0;
  endtask

  // Walks the replay of an n-symbol tape starting at the first LEAD cycle.
  // cd_cycle pulses compute_done for one cycle early; stop_k ends the walk there.
  task automatic replay(input string name, input int n, input int cd_cycle, input int stop_k);
    int total;
    logic [6:0] exp_v;
    logic [6:0] act_v;
    total = PER * n + SETUP + PULSE;
    for (int k = 1; k <= total; k++) begin
      int i;
      int p;
      int j;
      if (stop_k != 0 && k == stop_k) break;
      i = (k - 1) / PER;
      p = (k - 1) % PER;
      j = k - 1 - PER * n;
      if (i < n) exp_v = {1'b1, tape[i], (p >= SETUP && p < SETUP + PULSE), 1'b0};
      else       exp_v = {1'b1, 4'h0, 1'b0, (j >= SETUP && j < SETUP + PULSE)};
      act_v = {busy, input_data, next, done};
      checks++;
      if (act_v !== exp_v)
        $display("[TB] FAIL %s cycle %0d: {busy,data,next,done} got %b expected %b", name, k, act_v, exp_v);
      else passes++;
      if (k == cd_cycle) begin
        compute_done = 1'b1;
        display      = 11'h777;
      end
      step();
      compute_done = 1'b0;
    end
  endtask

  task automatic finish_result(input string name, input logic [10:0] disp);
    compute_done = 1'b1;
    display      = disp;
    step();
    compute_done = 1'b0;
    checks++;
    if (hif.result !== disp || hif.result_valid !== 1'b1)
      $display("[TB] FAIL %s capture: result=%h valid=%b expected %h/1", name, hif.result, hif.result_valid, disp);
    else passes++;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (hif.result_valid !== 1'b1 || hif.wr_ready !== 1'b0 || busy !== 1'b1)
        $display("[TB] FAIL %s hold: valid=%b wr_ready=%b busy=%b expected 1/0/1", name, hif.result_valid, hif.wr_ready, busy);
      else passes++;
    end
    hif.result_ack = 1'b1;
    step();
    hif.result_ack = 1'b0;
    checks++;
    if (hif.result_valid !== 1'b0 || busy !== 1'b0 || hif.wr_ready !== 1'b1 || hif.result !== disp)
      $display("[TB] FAIL %s ack: valid=%b busy=%b wr_ready=%b result=%h expected 0/0/1/%h",
               name, hif.result_valid, busy, hif.wr_ready, hif.result, disp);
    else passes++;
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, input_data, next, done, hif.result_valid, hif.result} !== 19'h0)
      $display("[TB] FAIL reset_outputs: busy=%b data=%h next=%b done=%b valid=%b result=%h expected all 0",
               busy, input_data, next, done, hif.result_valid, hif.result);
    else passes++;
    reset = 1'b1;
    step();
    checks++;
    if (hif.wr_ready !== 1'b1)
      $display("[TB] FAIL reset_wr_ready: got %b expected 1", hif.wr_ready);
    else passes++;
    // Results ignored outside RESULT and compute_done ignored in IDLE
    hif.result_ack = 1'b1;
    compute_done   = 1'b1;
    display        = 11'h3FF;
    step();
    hif.result_ack = 1'b0;
    compute_done   = 1'b0;
    checks++;
    if (busy !== 1'b0 || hif.result_valid !== 1'b0 || hif.result !== 11'h0)
      $display("[TB] FAIL idle_ignore: busy=%b valid=%b result=%h expected 0/0/000", busy, hif.result_valid, hif.result);
    else passes++;
  endtask

  task automatic test_single();
    tape[0] = 4'hA;
    write_sym(4'hA, 1'b1);
    replay("single", 1, 0, 0);
    finish_result("single", 11'h155);
  endtask

  task automatic test_three();
    tape[0] = 4'h1; tape[1] = 4'h2; tape[2] = 4'h3;
    write_sym(4'h1, 1'b0);
    write_sym(4'h2, 1'b0);
    write_sym(4'h3, 1'b1);
    replay("three", 3, 0, 0);
    finish_result("three", 11'h5A5);
  endtask

  task automatic test_full();
    for (int i = 0; i < 64; i++) begin
      tape[i] = 4'(i % 16);
      checks++;
      if (hif.wr_ready !== 1'b1)
        $display("[TB] FAIL full_wr_ready_%0d: got %b expected 1", i, hif.wr_ready);
      else passes++;
      write_sym(tape[i], 1'b0);
    end
    checks++;
    if (hif.wr_ready !== 1'b0)
      $display("[TB] FAIL full_ready_drop: got %b expected 0", hif.wr_ready);
    else passes++;
    replay("full", 64, 0, 0);
    finish_result("full", 11'h0C3);
  endtask

  task automatic test_compute_early();
    tape[0] = 4'h6;
    write_sym(4'h6, 1'b1);
    replay("early", 1, SETUP + 1, 0);
    checks++;
    if (hif.result_valid !== 1'b0 || busy !== 1'b1)
      $display("[TB] FAIL early_no_capture: valid=%b busy=%b expected 0/1", hif.result_valid, busy);
    else passes++;
    finish_result("early", 11'h123);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      tape[i] = 4'(4'hF - 4'(3 * i));
      write_sym(tape[i], i == 4);
    end
    replay("wrap", 5, 0, 0);
    finish_result("wrap", 11'h7E1);
  endtask

  task automatic test_mid_reset();
    tape[0] = 4'h4; tape[1] = 4'h5; tape[2] = 4'h6;
    write_sym(4'h4, 1'b0);
    write_sym(4'h5, 1'b0);
    write_sym(4'h6, 1'b1);
    replay("midreset", 3, 0, PER + SETUP + 1);
    checks++;
    if (next !== 1'b1)
      $display("[TB] FAIL midreset_in_strobe: next=%b expected 1", next);
    else passes++;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (next !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || input_data !== 4'h0 || hif.wr_ready !== 1'b1)
      $display("[TB] FAIL midreset_abort: next=%b done=%b busy=%b data=%h wr_ready=%b expected 0/0/0/0/1",
               next, done, busy, input_data, hif.wr_ready);
    else passes++;
    @(negedge clock);
    reset = 1'b1;
    step();
    tape[0] = 4'h9;
    write_sym(4'h9, 1'b1);
    replay("after_reset", 1, 0, 0);
    finish_result("after_reset", 11'h2B4);
  endtask

  initial begin
    hif.wr_data    = '0;
    hif.wr_last    = 1'b0;
    hif.wr_valid   = 1'b0;
    hif.result_ack = 1'b0;
    #12;
    test_reset();
    test_single();
    test_three();
    test_full();
    test_compute_early();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
